// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between the core's fetch port and load/store port, one transaction at a time.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data always wins over fetch.
module riscv_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_ack,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_W/8-1:0]   d_be,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_ack,
   output logic                  m_req,
   output logic                  m_we,
   output logic [DATA_W/8-1:0]   m_be,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic                  m_ready,
   output logic                  busy
);

   // state | meaning
   // IDLE  | waiting for a request; arbitration happens on the edge leaving this state
   // MEM   | m_req held with stable m_* until m_ready
   // RESP  | one-cycle ack to the winner; requests not sampled

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } grant_e;

   state_e              state_q,    state_d;
   grant_e              grant_q,    grant_d;
   logic                m_req_q,    m_req_d;
   logic                m_we_q,     m_we_d;
   logic [BE_W-1:0]     m_be_q,     m_be_d;
   logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
   logic                if_ack_q,   if_ack_d;
   logic                d_ack_q,    d_ack_d;
   logic                busy_q,     busy_d;
   logic                win_data;

`ifdef ARB_RR_EN
   grant_e              last_grant_q, last_grant_d;

   // On a tie the requester that did not win last time goes first.
   assign win_data = d_req && (!if_req || (last_grant_q == GNT_FETCH));
`else
   assign win_data = d_req;
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_be_d     = m_be_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
`ifdef ARB_RR_EN
      last_grant_d = last_grant_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (if_req || d_req) begin
               state_d = ST_MEM;
               m_req_d = 1'b1;
               if (win_data) begin
                  grant_d   = GNT_DATA;
                  m_we_d    = d_we;
                  m_be_d    = d_be;
                  m_addr_d  = d_addr;
                  m_wdata_d = d_wdata;
               end else begin
                  grant_d   = GNT_FETCH;
                  m_we_d    = 1'b0;
                  m_be_d    = '1;
                  m_addr_d  = if_addr;
                  m_wdata_d = '0;
               end
`ifdef ARB_RR_EN
               last_grant_d = win_data ? GNT_DATA : GNT_FETCH;
`endif
            end
         end
         ST_MEM: begin
            if (m_ready) begin
               m_req_d = 1'b0;
               state_d = ST_RESP;
               if (grant_q == GNT_DATA) begin
                  d_ack_d = 1'b1;
                  // Stores leave the load-data register untouched.
                  if (!m_we_q) begin
                     d_rdata_d = m_rdata;
                  end
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = m_rdata;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            m_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= GNT_FETCH;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_be_q     <= '0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef ARB_RR_EN
         last_grant_q <= GNT_FETCH;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_be_q     <= m_be_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         busy_q     <= busy_d;
`ifdef ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_be     = m_be_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign if_ack   = if_ack_q;
   assign d_ack    = d_ack_q;
   assign busy     = busy_q;

endmodule
